control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, maximum cycles MEM waits for mem_ack before trapping (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  instruction opcode from the datapath.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7  input  7  instruction funct7.
REQ-007 mem_ack  input  1  data-memory access complete.
REQ-008 reg_wr, sel_A, sel_B  output  1 each  register write strobe; A source (0 PC, 1 RD1); B source (0 RD2, 1 Imm).
REQ-009 wb_sel  output  2  00 PC+4, 01 ALUResult, 10 rdata.
REQ-010 ImmSrc  output  3  000 I, 001 S, 010 B, 011 U, 100 J.
REQ-011 alu_op  output  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B.
REQ-012 br_type  output  3  000 never, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 always.
REQ-013 ReadControl  output  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU.
REQ-014 WriteControl  output  3  000 none, 001 SB, 010 SH, 011 SW.
REQ-015 pc_en, mem_req  output  1 each  PC update enable; data-memory request.
REQ-016 trap  output  1  sticky illegal-instruction/timeout flag.
REQ-017 instret  output  32  retired-instruction counter.

Function
REQ-018 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; FETCH->DECODE->EXEC unconditionally.
REQ-019 DECODE registers opcode/funct3/funct7; all decoded outputs derive from the registered copy and hold until next DECODE.
REQ-020 EXEC->MEM for load (0000011) / store (0100011); EXEC->WB otherwise; illegal opcode or funct3 (e.g. load funct3 011/110/111) -> TRAP from DECODE.
REQ-021 mem_req high throughout MEM; MEM->WB in the cycle after mem_ack sampled high; ReadControl/WriteControl nonzero only in MEM.
REQ-022 8-bit wait counter cleared on MEM entry, increments each MEM cycle without mem_ack; reaching MEM_TIMEOUT -> TRAP, mem_req drops.
REQ-023 WB: one-cycle reg_wr (not for store/branch), one-cycle pc_en, instret += 1 (wraps 0xFFFFFFFF->0), then FETCH.
REQ-024 br_type is 000 outside WB; branch/JAL/JALR drive their code only in WB so PC selection coincides with pc_en.
REQ-025 R-type: sel_A 1, sel_B 0, wb_sel 01; alu_op from funct3 with funct7[5] selecting SUB/SRA.
REQ-026 I-ALU: sel_B 1, ImmSrc 000; funct7[5] honoured only for SRAI; loads ADD, wb_sel 10; stores ADD, ImmSrc 001.
REQ-027 LUI: alu_op PASS_B, ImmSrc 011; AUIPC: sel_A 0, ADD, ImmSrc 011; JAL: sel_A 0, ImmSrc 100, wb_sel 00, br_type 111; JALR: sel_A 1, ImmSrc 000, wb_sel 00, br_type 111.
REQ-028 B-type: sel_A 0, sel_B 1, ImmSrc 010, ADD, reg_wr 0, br_type from funct3 (000->001, 001->010, 100->011, 101->100, 110->101, 111->110).
REQ-029 TRAP is absorbing: trap=1, all strobes 0, only reset exits.
REQ-030 Instruction latency: 4 cycles non-memory; 5+N for memory where N = cycles before mem_ack.

Reset
REQ-031 On rst low: state FETCH, trap 0, instret 0, wait counter 0, registered fields 0, all strobes and control outputs 0, effective immediately regardless of state (including mid-MEM).

Structure
REQ-032 Opcode constants, state enum, and alu_op/br_type/ImmSrc/wb_sel/Read/WriteControl encodings live in shared package rv32i_pkg.
REQ-033 Combinational decode lives in one sub-module, main_decoder; control_fsm holds state, counters and strobe gating.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093) -> FETCH,DECODE,EXEC,WB; reg_wr and pc_en high only in cycle 4; alu_op 0000, sel_B 1, wb_sel 01; instret 0->1.
REQ-035 LW (0x0000A083), mem_ack asserted 3 cycles after MEM entry -> mem_req high 4 cycles, ReadControl 011, reg_wr in following WB, total 8 cycles.
REQ-036 BNE (opcode 1100011, funct3 001) -> br_type 010 only in WB, reg_wr 0, pc_en 1.
REQ-037 opcode 0000000 -> TRAP after DECODE, trap 1, pc_en never asserted, instret unchanged.
REQ-038 SW with mem_ack held low, MEM_TIMEOUT 15 -> TRAP after 15 MEM cycles, mem_req drops.
REQ-039 rst low mid-MEM -> outputs 0 asynchronously; after release, FETCH and instret 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode constants, FSM state enum, control-field encodings and decode helpers
// shared by control_fsm and main_decoder.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {BR_NEVER, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_ALWAYS} br_type_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;
    typedef enum logic [1:0] {WB_PC4, WB_ALU, WB_RDATA} wb_sel_t;
    typedef enum logic [2:0] {RD_NONE, RD_LB, RD_LH, RD_LW, RD_LBU, RD_LHU} read_ctl_t;
    typedef enum logic [2:0] {WR_NONE, WR_SB, WR_SH, WR_SW} write_ctl_t;

    typedef struct packed {
        logic       reg_wr;
        logic       is_mem;
        logic       sel_a;
        logic       sel_b;
        wb_sel_t    wb_sel;
        imm_src_t   imm_src;
        alu_op_t    alu_op;
        br_type_t   br_type;
        read_ctl_t  read_ctl;
        write_ctl_t write_ctl;
    } ctrl_t;

    // RV32I legality of an opcode/funct3/funct7 triple; funct7 only matters where it
    // encodes an operation (R-type and the shift immediates).
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            OP_REG:    return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OP_IMM:    return f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OP_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            OP_STORE:  return f3 < 3'd3;
            OP_BRANCH: return f3[2:1] != 2'b01;
            OP_JALR:   return f3 == 3'd0;
            OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // funct3 -> ALU op; alt selects SUB/SRA and is only raised for funct3 000/101.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] w;
        w = {1'b0, f3};
        return alt ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA)
                   : alu_op_t'(f3 == 3'd0 ? 4'd0 : f3 < 3'd6 ? w + 4'd1 : w + 4'd2);
    endfunction

endpackage

// File: rtl/main_decoder.sv
// main_decoder: combinational instruction decode into an ungated control bundle.
// Ports: opcode/funct3/funct7 (registered instruction fields) in; ctrl (ctrl_t) out,
// all-zero for an illegal instruction.
module main_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (is_legal(opcode, funct3, funct7)) begin
            ctrl.sel_a  = 1'b1;
            ctrl.sel_b  = 1'b1;
            ctrl.reg_wr = 1'b1;
            ctrl.wb_sel = WB_ALU;
            case (opcode)
                OP_REG: begin
                    ctrl.sel_b  = 1'b0;
                    ctrl.alu_op = alu_from_f3(funct3, funct7[5]);
                end
                OP_IMM: ctrl.alu_op = alu_from_f3(funct3, funct3 == 3'd5 && funct7[5]);
                OP_LOAD: begin
                    ctrl.is_mem   = 1'b1;
                    ctrl.wb_sel   = WB_RDATA;
                    ctrl.read_ctl = read_ctl_t'(funct3[2] ? 3'd4 + {2'b0, funct3[0]} : {1'b0, funct3[1:0]} + 3'd1);
                end
                OP_STORE: begin
                    ctrl.is_mem    = 1'b1;
                    ctrl.reg_wr    = 1'b0;
                    ctrl.imm_src   = IMM_S;
                    ctrl.write_ctl = write_ctl_t'(funct3 + 3'd1);
                end
                OP_BRANCH: begin
                    ctrl.sel_a   = 1'b0;
                    ctrl.reg_wr  = 1'b0;
                    ctrl.imm_src = IMM_B;
                    // 000,001 -> BEQ,BNE ; 100..111 -> BLT..BGEU
                    ctrl.br_type = br_type_t'(funct3[2] ? funct3 - 3'd1 : funct3 + 3'd1);
                end
                OP_LUI: begin
                    ctrl.sel_a   = 1'b0;
                    ctrl.imm_src = IMM_U;
                    ctrl.alu_op  = ALU_PASS_B;
                end
                OP_AUIPC: begin
                    ctrl.sel_a   = 1'b0;
                    ctrl.imm_src = IMM_U;
                end
                OP_JAL: begin
                    ctrl.sel_a   = 1'b0;
                    ctrl.imm_src = IMM_J;
                    ctrl.wb_sel  = WB_PC4;
                    ctrl.br_type = BR_ALWAYS;
                end
                OP_JALR: begin
                    ctrl.wb_sel  = WB_PC4;
                    ctrl.br_type = BR_ALWAYS;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Ports: clk, rst (async active-low); opcode/funct3/funct7/mem_ack in;
// reg_wr, sel_A, sel_B, wb_sel, ImmSrc, alu_op, br_type, ReadControl, WriteControl,
// pc_en, mem_req, trap, instret out.
module control_fsm
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        mem_ack,
    output logic        reg_wr,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  wb_sel,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  alu_op,
    output logic [2:0]  br_type,
    output logic [2:0]  ReadControl,
    output logic [2:0]  WriteControl,
    output logic        pc_en,
    output logic        mem_req,
    output logic        trap,
    output logic [31:0] instret
);

    state_t     state, next;
    logic [6:0] op_q, f7_q;
    logic [2:0] f3_q;
    logic [7:0] wait_cnt;
    ctrl_t      ctrl;

    main_decoder u_dec (.opcode(op_q), .funct3(f3_q), .funct7(f7_q), .ctrl(ctrl));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            op_q     <= '0;
            f3_q     <= '0;
            f7_q     <= '0;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state <= next;
            if (state == DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
                f7_q <= funct7;
            end
            // Held at zero outside MEM, so every MEM entry starts a fresh count.
            wait_cnt <= state == MEM && !mem_ack ? wait_cnt + 8'd1 : 8'd0;
            if (state == WB) instret <= instret + 32'd1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            FETCH:  next = DECODE;
            // Legality is judged on the live fields, before they are captured.
            DECODE: next = is_legal(opcode, funct3, funct7) ? EXEC : TRAP;
            EXEC:   next = ctrl.is_mem ? MEM : WB;
            MEM:    next = mem_ack ? WB : wait_cnt == 8'(MEM_TIMEOUT - 1) ? TRAP : MEM;
            WB:     next = FETCH;
            TRAP:   next = TRAP;
            default: next = FETCH;
        endcase
    end

    assign sel_A        = ctrl.sel_a;
    assign sel_B        = ctrl.sel_b;
    assign wb_sel       = ctrl.wb_sel;
    assign ImmSrc       = ctrl.imm_src;
    assign alu_op       = ctrl.alu_op;
    assign reg_wr       = state == WB && ctrl.reg_wr;
    assign pc_en        = state == WB;
    assign br_type      = state == WB ? ctrl.br_type : BR_NEVER;
    assign mem_req      = state == MEM;
    assign ReadControl  = state == MEM ? ctrl.read_ctl : RD_NONE;
    assign WriteControl = state == MEM ? ctrl.write_ctl : WR_NONE;
    assign trap         = state == TRAP;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed and randomized instruction streams against a latency/decode model.
module tb_control_fsm;

    localparam int TO = 15;

    logic        clk, rst, mem_ack;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        reg_wr, sel_A, sel_B, pc_en, mem_req, trap;
    logic [1:0]  wb_sel;
    logic [2:0]  ImmSrc, br_type, ReadControl, WriteControl;
    logic [3:0]  alu_op;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instret = 0;

    control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ack(mem_ack), .reg_wr(reg_wr), .sel_A(sel_A), .sel_B(sel_B), .wb_sel(wb_sel),
        .ImmSrc(ImmSrc), .alu_op(alu_op), .br_type(br_type), .ReadControl(ReadControl),
        .WriteControl(WriteControl), .pc_en(pc_en), .mem_req(mem_req), .trap(trap),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       legal, mem, wr, sa, sb, dc_sa, dc_wb;
        logic [1:0] wb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [2:0] br, rc, wc;
    } exp_t;

    // Expected decode straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] tab;
        logic [3:0]  base;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        tab  = 32'h98654320;
        base = tab[f3*4 +: 4];
        e = '0;
        e.legal = 1; e.sa = 1; e.sb = 1; e.wr = 1; e.wb = 2'd1;
        case (op)
            7'h33: begin
                e.legal = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.sb = 0;
                e.alu = f7[5] ? (f3 == 0 ? 4'd1 : 4'd7) : base;
            end
            7'h13: begin
                e.legal = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.alu = (f3 == 5 && f7[5]) ? 4'd7 : base;
            end
            7'h03: begin
                e.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.mem = 1; e.wb = 2'd2;
                e.rc = f3 == 0 ? 3'd1 : f3 == 1 ? 3'd2 : f3 == 2 ? 3'd3 : f3 == 4 ? 3'd4 : 3'd5;
            end
            7'h23: begin
                e.legal = f3 < 3; e.mem = 1; e.wr = 0; e.imm = 3'd1; e.wc = f3 + 3'd1; e.dc_wb = 1;
            end
            7'h63: begin
                e.legal = !(f3 == 2 || f3 == 3); e.sa = 0; e.imm = 3'd2; e.wr = 0; e.dc_wb = 1;
                e.br = f3 == 0 ? 3'd1 : f3 == 1 ? 3'd2 : f3 == 4 ? 3'd3 : f3 == 5 ? 3'd4 : f3 == 6 ? 3'd5 : 3'd6;
            end
            7'h37: begin e.imm = 3'd3; e.alu = 4'd10; e.dc_sa = 1; end
            7'h17: begin e.sa = 0; e.imm = 3'd3; end
            7'h6F: begin e.sa = 0; e.imm = 3'd4; e.wb = 2'd0; e.br = 3'd7; end
            7'h67: begin e.legal = f3 == 0; e.wb = 2'd0; e.br = 3'd7; end
            default: e.legal = 0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Async reset, checked half a cycle away from any edge, released on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_strobes", {19'd0, reg_wr, pc_en, mem_req, trap, br_type, ReadControl, WriteControl}, 0);
        check("rst_ctrl", {21'd0, sel_A, sel_B, wb_sel, ImmSrc, alu_op}, 0);
        check("rst_instret", instret, 0);
        exp_instret = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one instruction from FETCH; n = no-ack MEM cycles before mem_ack (n >= TO: never).
    // Entered and left on a falling edge.
    task automatic run(input logic [31:0] ins, input int n);
        exp_t e;
        logic tr, wb_now, mreq;
        int   len;
        e   = model(ins);
        tr  = !e.legal || (e.mem && n >= TO);
        len = !e.legal ? 3 : e.mem ? (n >= TO ? 4 + TO : 5 + n) : 4;
        opcode = ins[6:0];
        funct3 = ins[14:12];
        funct7 = ins[31:25];
        check("instret_start", instret, exp_instret);
        for (int k = 1; k <= len; k++) begin
            wb_now = !tr && k == len;
            mreq   = e.mem && e.legal && k >= 4 && k < len;
            check("pc_en", pc_en, wb_now);
            check("reg_wr", reg_wr, wb_now && e.wr);
            check("mem_req", mem_req, mreq);
            check("br_type", br_type, wb_now ? e.br : 3'd0);
            check("read_ctl", ReadControl, mreq ? e.rc : 3'd0);
            check("write_ctl", WriteControl, mreq ? e.wc : 3'd0);
            check("trap", trap, tr && k == len);
            if (wb_now) begin
                if (!e.dc_sa) check("sel_A", sel_A, e.sa);
                check("sel_B", sel_B, e.sb);
                if (!e.dc_wb) check("wb_sel", wb_sel, e.wb);
                check("ImmSrc", ImmSrc, e.imm);
                check("alu_op", alu_op, e.alu);
            end
            if (tr && k == len) break;
            mem_ack = e.mem && !tr && k == 4 + n;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        if (tr) begin
            check("trap_instret", instret, exp_instret);
        end else begin
            exp_instret++;
            check("instret_end", instret, exp_instret);
        end
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] ins;
        logic [6:0]  f7;
        int          n;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00, 7'h73, 7'h0F};
        rst = 1'b0; mem_ack = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        @(negedge clk);
        do_reset();

        run(32'h00500093, 0);            // ADDI x1,x0,5
        run(32'h0000A083, 3);            // LW, ack after 3 waiting cycles
        run(32'h00209463, 0);            // BNE
        run(32'h40208133, 0);            // SUB
        run(32'h4050D093, 0);            // SRAI
        run(32'h0020A023, TO);           // SW, ack never comes
        do_reset();
        run(32'h00000000, 0);            // illegal opcode
        do_reset();
        run(32'h0000B083, 0);            // load funct3 011 is illegal
        do_reset();

        run(32'h00500093, 0);
        opcode = 7'h03; funct3 = 3'd1; funct7 = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_mem_req", mem_req, 1);
        check("mid_mem_rc", ReadControl, 3'd2);
        do_reset();
        run(32'h00500093, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h20;
                1:       f7 = 7'($urandom);
                default: f7 = 7'h00;
            endcase
            ins = {f7, 10'($urandom), 3'($urandom), 5'($urandom), ops[$urandom_range(0, 11)]};
            n = $urandom_range(0, 15) == 0 ? TO : $urandom_range(0, 4);
            run(ins, n);
            if (trap) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
